// File: rtl/alarm_ringer.sv
// Alarm ringer: runs the ring / snooze / dismiss sequence from the alarm-match level
// and drives a gated square-wave buzzer plus the ring and snooze indicators.
module alarm_ringer #(
  parameter int unsigned TONE_DIV    = 25000,
  parameter int unsigned BEEP_DIV    = 12500000,
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       al_on,
  input  logic       al_enable,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic       buzzer,
  output logic       ring_led,
  output logic       snoozing,
  output logic [1:0] ring_state
);

  localparam int unsigned TONE_W = 16;
  localparam int unsigned BEEP_W = 24;
  localparam int unsigned SEC_W  = 9;
  localparam int unsigned SNZ_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RING   = 2'b01,
    SNOOZE = 2'b10,
    DONE   = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [SEC_W-1:0]    sec_cnt_q, sec_cnt_d;
  logic [SNZ_W-1:0]    snz_cnt_q, snz_cnt_d;
  logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic [BEEP_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic                tone_sq_q, tone_sq_d;
  logic                beat_q, beat_d;
  logic                buzzer_q, buzzer_d;
  logic                ring_led_q, snoozing_q;
  logic [2:0]          stop_sync_q, snz_sync_q;
  logic                al_q;
  logic                stop_press, snz_press, al_rise;

  // Two-flop synchronizers with a third delay flop for single-cycle press detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      stop_sync_q <= '0;
      snz_sync_q  <= '0;
    end else begin
      stop_sync_q <= {stop_sync_q[1:0], btn_stop};
      snz_sync_q  <= {snz_sync_q[1:0], btn_snooze};
    end
  end

  // al_q keeps tracking through reset so a match level held across reset is not a new rise.
  always_ff @(posedge clk) begin
    al_q <= al_on;
  end

  assign stop_press = stop_sync_q[1] & ~stop_sync_q[2];
  assign snz_press  = snz_sync_q[1] & ~snz_sync_q[2];
  assign al_rise    = al_on & ~al_q;

  always_comb begin
    state_d    = state_q;
    snz_cnt_d  = snz_cnt_q;
    sec_cnt_d  = sec_cnt_q;
    tone_cnt_d = '0;
    beat_cnt_d = '0;
    tone_sq_d  = 1'b0;
    beat_d     = 1'b0;

    if (state_q == IDLE) snz_cnt_d = '0;

    if (!al_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (al_rise) state_d = RING;
        RING: begin
          if (stop_press) begin
            state_d = DONE;
          end else if (snz_press && (snz_cnt_q < SNZ_W'(MAX_SNOOZE))) begin
            state_d   = SNOOZE;
            snz_cnt_d = snz_cnt_q + SNZ_W'(1);
          end else if (tick_1hz && (sec_cnt_q == SEC_W'(RING_SECS - 1))) begin
            state_d = DONE;
          end
        end
        SNOOZE: begin
          if (stop_press) begin
            state_d = DONE;
          end else if (tick_1hz && (sec_cnt_q == SEC_W'(SNOOZE_SECS - 1))) begin
            state_d = RING;
          end
        end
        DONE: if (!al_on) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (state_d != state_q) sec_cnt_d = '0;
    else if (tick_1hz)      sec_cnt_d = sec_cnt_q + SEC_W'(1);

    // Tone and beat generators run only while staying in RING; zero otherwise and on entry.
    if ((state_q == RING) && (state_d == RING)) begin
      tone_sq_d = tone_sq_q;
      beat_d    = beat_q;
      if (tone_cnt_q == TONE_W'(TONE_DIV - 1)) begin
        tone_cnt_d = '0;
        tone_sq_d  = ~tone_sq_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TONE_W'(1);
      end
      if (beat_cnt_q == BEEP_W'(BEEP_DIV - 1)) begin
        beat_cnt_d = '0;
        beat_d     = ~beat_q;
      end else begin
        beat_cnt_d = beat_cnt_q + BEEP_W'(1);
      end
    end

    buzzer_d = (state_q == RING) & tone_sq_q & ~beat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sec_cnt_q  <= '0;
      snz_cnt_q  <= '0;
      tone_cnt_q <= '0;
      beat_cnt_q <= '0;
      tone_sq_q  <= 1'b0;
      beat_q     <= 1'b0;
      buzzer_q   <= 1'b0;
      ring_led_q <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sec_cnt_q  <= sec_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      tone_sq_q  <= tone_sq_d;
      beat_q     <= beat_d;
      buzzer_q   <= buzzer_d;
      ring_led_q <= (state_d == RING);
      snoozing_q <= (state_d == SNOOZE);
    end
  end

  assign buzzer     = buzzer_q;
  assign ring_led   = ring_led_q;
  assign snoozing   = snoozing_q;
  assign ring_state = state_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed self-checking bench for alarm_ringer with shortened timing parameters.
module tb_alarm_ringer;

  logic       clk = 1'b0;
  logic       rst, tick_1hz, al_on, al_enable, btn_stop, btn_snooze;
  logic       buzzer, ring_led, snoozing;
  logic [1:0] ring_state;

  int checks   = 0;
  int failures = 0;

  alarm_ringer #(
    .TONE_DIV(2), .BEEP_DIV(8), .RING_SECS(4), .SNOOZE_SECS(3), .MAX_SNOOZE(1)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .al_on(al_on), .al_enable(al_enable),
    .btn_stop(btn_stop), .btn_snooze(btn_snooze), .buzzer(buzzer), .ring_led(ring_led),
    .snoozing(snoozing), .ring_state(ring_state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [20:0] buz_exp;
    int          trans;
    logic [1:0]  prev;

    rst = 1'b1; tick_1hz = 1'b0; al_on = 1'b0; al_enable = 1'b0;
    btn_stop = 1'b0; btn_snooze = 1'b0;
    cyc(); cyc();
    chk("reset_state", int'(ring_state), 0);
    chk("reset_buzzer", int'(buzzer), 0);
    chk("reset_led", int'(ring_led), 0);
    chk("reset_snoozing", int'(snoozing), 0);
    rst = 1'b0;

    // 1. trigger and tone
    al_enable = 1'b1;
    cyc();
    chk("idle_no_al", int'(ring_state), 0);
    al_on = 1'b1;
    cyc();
    chk("trig_state", int'(ring_state), 1);
    chk("trig_led", int'(ring_led), 1);
    buz_exp = '0;
    buz_exp[3] = 1'b1; buz_exp[4] = 1'b1; buz_exp[7] = 1'b1; buz_exp[8] = 1'b1;
    buz_exp[19] = 1'b1; buz_exp[20] = 1'b1;
    chk("tone_k0", int'(buzzer), int'(buz_exp[0]));
    for (int k = 1; k <= 20; k++) begin
      cyc();
      chk($sformatf("tone_k%0d", k), int'(buzzer), int'(buz_exp[k]));
    end

    // 2. timeout then DONE hold
    tick(); tick(); tick();
    chk("ring_before_timeout", int'(ring_state), 1);
    tick();
    chk("timeout_done", int'(ring_state), 3);
    cyc();
    chk("done_buzzer", int'(buzzer), 0);
    chk("done_led", int'(ring_led), 0);
    repeat (5) cyc();
    tick();
    chk("done_hold", int'(ring_state), 3);
    al_on = 1'b0;
    cyc();
    chk("done_release", int'(ring_state), 0);

    // 3. snooze cycle
    al_on = 1'b1;
    cyc();
    chk("retrig", int'(ring_state), 1);
    btn_snooze = 1'b1;
    cyc(); cyc();
    chk("snz_latency_hold", int'(ring_state), 1);
    cyc();
    btn_snooze = 1'b0;
    chk("snz_state", int'(ring_state), 2);
    chk("snz_flag", int'(snoozing), 1);
    chk("snz_led", int'(ring_led), 0);
    cyc();
    chk("snz_buzzer", int'(buzzer), 0);
    tick(); tick();
    chk("snz_before_end", int'(ring_state), 2);
    tick();
    chk("snz_end_ring", int'(ring_state), 1);
    chk("snz_end_flag", int'(snoozing), 0);
    btn_snooze = 1'b1;
    repeat (5) cyc();
    btn_snooze = 1'b0;
    chk("snz_max_ignored", int'(ring_state), 1);
    btn_stop = 1'b1;
    cyc(); cyc(); cyc();
    btn_stop = 1'b0;
    chk("stop_after_snz", int'(ring_state), 3);

    // 4. simultaneous presses and enable priority
    al_on = 1'b0;
    cyc();
    chk("idle_again", int'(ring_state), 0);
    al_on = 1'b1;
    cyc();
    chk("ring_for_both", int'(ring_state), 1);
    btn_stop = 1'b1; btn_snooze = 1'b1;
    cyc(); cyc(); cyc();
    btn_stop = 1'b0; btn_snooze = 1'b0;
    chk("both_pressed", int'(ring_state), 3);
    al_on = 1'b0;
    cyc();
    al_on = 1'b1;
    cyc();
    chk("ring_for_enable", int'(ring_state), 1);
    btn_stop = 1'b1;
    cyc(); cyc();
    al_enable = 1'b0;
    cyc();
    chk("enable_over_stop", int'(ring_state), 0);
    btn_stop = 1'b0; al_enable = 1'b1;
    repeat (3) cyc();
    chk("level_no_trigger", int'(ring_state), 0);

    // 5. button hold and latency
    al_on = 1'b0;
    cyc();
    al_on = 1'b1;
    cyc();
    chk("ring_for_hold", int'(ring_state), 1);
    btn_stop = 1'b1;
    trans = 0;
    prev  = ring_state;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (i == 1) chk("hold_n1", int'(ring_state), 1);
      if (i == 2) chk("hold_n2", int'(ring_state), 3);
      if (ring_state != prev) trans++;
      prev = ring_state;
    end
    btn_stop = 1'b0;
    chk("hold_transitions", trans, 1);
    chk("hold_final", int'(ring_state), 3);
    al_on = 1'b0;
    cyc();
    chk("hold_release", int'(ring_state), 0);

    // 6. reset mid-RING
    al_on = 1'b1;
    cyc();
    chk("ring_for_reset", int'(ring_state), 1);
    cyc(); cyc(); cyc();
    chk("buzz_before_reset", int'(buzzer), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_state", int'(ring_state), 0);
    chk("rst_buzzer", int'(buzzer), 0);
    chk("rst_led", int'(ring_led), 0);
    chk("rst_snoozing", int'(snoozing), 0);
    repeat (4) cyc();
    chk("rst_no_retrig", int'(ring_state), 0);
    al_on = 1'b0;
    cyc();
    al_on = 1'b1;
    cyc();
    chk("rst_rise_retrig", int'(ring_state), 1);
    al_enable = 1'b0;
    cyc();
    chk("disable_idle", int'(ring_state), 0);
    chk("disable_led", int'(ring_led), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
